riscv_dmem_ctrl: RTL and testbench



---
 rtl/riscv_dmem_ctrl_if.sv | 36 +++
 rtl/riscv_dmem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_riscv_dmem_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_ctrl_if.sv
// Request/response and memory-side signal bundle for riscv_dmem_ctrl.
// slave = the controller, master = requesters plus the data memory.
interface riscv_dmem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic                  c_req_valid, c_req_ready, c_req_we;
  logic [2:0]            c_req_funct3;
  logic [ADDR_WIDTH-1:0] c_req_addr;
  logic [DATA_WIDTH-1:0] c_req_wdata;
  logic                  d_req_valid, d_req_ready, d_req_we;
  logic [2:0]            d_req_funct3;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic [DATA_WIDTH-1:0] d_req_wdata;
  logic                  c_rsp_valid, d_rsp_valid, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mem_en, mem_wen;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  c_req_valid, c_req_we, c_req_funct3, c_req_addr, c_req_wdata,
    input  d_req_valid, d_req_we, d_req_funct3, d_req_addr, d_req_wdata,
    output c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid, rsp_rdata, rsp_err,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req_valid, c_req_we, c_req_funct3, c_req_addr, c_req_wdata,
    output d_req_valid, d_req_we, d_req_funct3, d_req_addr, d_req_wdata,
    input  c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid, rsp_rdata, rsp_err,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/riscv_dmem_ctrl.sv
// Load/store controller for a single-port word memory: core + debug round-robin,
// RMW for sub-word stores. Debug port live only when DMEM_CTRL_DBG_PORT_EN is defined.
module riscv_dmem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic            clk,
  input  logic            reset,
  riscv_dmem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t                r_state;
  logic                  r_we, r_owner, r_last_dbg;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_mem_en, r_mem_wen, r_rsp_err, r_c_rsp, r_d_rsp;
  logic [DATA_WIDTH-1:0] r_mem_wdata, r_rsp_rdata;

  logic                  w_idle, w_gnt_c, w_gnt_d;
  logic                  w_we, w_ill, w_mis, w_err;
  logic [2:0]            w_f3;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata, w_lane, w_ext, w_mask, w_merged;
  logic [4:0]            w_shamt;

  assign w_idle = (r_state == IDLE) && !reset;

`ifdef DMEM_CTRL_DBG_PORT_EN
  // On contention the requester that did not win last time goes first.
  assign w_gnt_c = w_idle && bus.c_req_valid && (!bus.d_req_valid || r_last_dbg);
  assign w_gnt_d = w_idle && bus.d_req_valid && (!bus.c_req_valid || !r_last_dbg);
  assign w_we    = w_gnt_d ? bus.d_req_we     : bus.c_req_we;
  assign w_f3    = w_gnt_d ? bus.d_req_funct3 : bus.c_req_funct3;
  assign w_addr  = w_gnt_d ? bus.d_req_addr   : bus.c_req_addr;
  assign w_wdata = w_gnt_d ? bus.d_req_wdata  : bus.c_req_wdata;
`else
  logic w_unused_dbg;
  assign w_unused_dbg = ^{bus.d_req_valid, bus.d_req_we, bus.d_req_funct3,
                          bus.d_req_addr, bus.d_req_wdata, r_last_dbg};
  assign w_gnt_c = w_idle && bus.c_req_valid;
  assign w_gnt_d = 1'b0;
  assign w_we    = bus.c_req_we;
  assign w_f3    = bus.c_req_funct3;
  assign w_addr  = bus.c_req_addr;
  assign w_wdata = bus.c_req_wdata;
`endif

  always_comb begin
    w_ill = 1'b1;
    case (w_f3)
      3'b000, 3'b001, 3'b010: w_ill = 1'b0;
      3'b100, 3'b101:         w_ill = w_we;
      default:                w_ill = 1'b1;
    endcase
  end
  assign w_mis = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                 ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
  assign w_err = w_ill || w_mis;

  // Lane select / merge operate on the word read back in WAIT.
  assign w_shamt = {r_addr[1:0], 3'b000};
  assign w_lane  = bus.mem_rdata >> w_shamt;

  always_comb begin
    w_ext = w_lane;
    case (r_f3)
      3'b000:  w_ext = {{24{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {24'd0, w_lane[7:0]};
      3'b101:  w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  assign w_mask   = (r_f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shamt;
  assign w_merged = (bus.mem_rdata & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_f3        <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_owner     <= 1'b0;
      r_last_dbg  <= 1'b1;
      r_mem_en    <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_c_rsp     <= 1'b0;
      r_d_rsp     <= 1'b0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_c_rsp     <= 1'b0;
      r_d_rsp     <= 1'b0;
      case (r_state)
        IDLE: if (w_gnt_c || w_gnt_d) begin
          r_we       <= w_we;
          r_f3       <= w_f3;
          r_addr     <= w_addr;
          r_wdata    <= w_wdata;
          r_owner    <= w_gnt_d;
          r_last_dbg <= w_gnt_d;
          if (w_err) begin
            r_state   <= RESP;
            r_rsp_err <= 1'b1;
            r_c_rsp   <= !w_gnt_d;
            r_d_rsp   <= w_gnt_d;
          end else if (w_we && (w_f3 == 3'b010)) begin
            r_state     <= WR;
            r_mem_en    <= 1'b1;
            r_mem_wen   <= 1'b1;
            r_mem_wdata <= w_wdata;
          end else begin
            r_state  <= RD;
            r_mem_en <= 1'b1;
          end
        end
        RD: r_state <= WAIT;
        WAIT: if (r_we) begin
          r_state     <= WR;
          r_mem_en    <= 1'b1;
          r_mem_wen   <= 1'b1;
          r_mem_wdata <= w_merged;
        end else begin
          r_state     <= RESP;
          r_rsp_rdata <= w_ext;
          r_c_rsp     <= !r_owner;
          r_d_rsp     <= r_owner;
        end
        WR: begin
          r_state <= RESP;
          r_c_rsp <= !r_owner;
          r_d_rsp <= r_owner;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gate with reset so a write landing on the reset cycle never reaches memory.
  assign bus.c_req_ready = w_gnt_c;
  assign bus.d_req_ready = w_gnt_d;
  assign bus.c_rsp_valid = r_c_rsp && !reset;
  assign bus.d_rsp_valid = r_d_rsp && !reset;
  assign bus.rsp_err     = r_rsp_err && !reset;
  assign bus.rsp_rdata   = reset ? '0 : r_rsp_rdata;
  assign bus.mem_en      = r_mem_en && !reset;
  assign bus.mem_wen     = r_mem_wen && !reset;
  assign bus.mem_wdata   = reset ? '0 : r_mem_wdata;
  assign bus.mem_addr    = reset ? '0 : r_addr[ADDR_WIDTH-1:2];
endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Randomized bench for riscv_dmem_ctrl against a byte-array reference model.
module tb_riscv_dmem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  riscv_dmem_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) bus();
  riscv_dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] tmem  [0:8191];
  logic [7:0]  rbyte [0:32767];
  int n_chk = 0;
  int n_fail = 0;

  // Data memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_wen) bus.mem_rdata <= tmem[bus.mem_addr];
    if (bus.mem_en && bus.mem_wen)  tmem[bus.mem_addr] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V byte-addressed semantics on a flat byte array.
  function automatic void model(input bit we, input bit [2:0] f3, input bit [14:0] a,
                                input bit [31:0] wd, output bit err, output int lat,
                                output bit [31:0] rd, output bit [31:0] wword);
    int sz;
    int base;
    bit legal;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err = !legal || ((int'(a) % sz) != 0);
    rd = 0;
    wword = 0;
    if (err) lat = 1;
    else if (we) begin
      for (int i = 0; i < sz; i++) rbyte[int'(a) + i] = wd[8*i +: 8];
      base = (int'(a) / 4) * 4;
      for (int i = 0; i < 4; i++) wword[8*i +: 8] = rbyte[base + i];
      lat = (sz == 4) ? 2 : 4;
    end else begin
      for (int i = 0; i < sz; i++) rd = rd | (32'(rbyte[int'(a) + i]) << (8*i));
      if (!f3[2] && sz < 4 && rd[8*sz-1]) rd = rd | ~((32'd1 << (8*sz)) - 32'd1);
      lat = 3;
    end
  endfunction

  task automatic drive(input bit dbg, input bit v, input bit we, input bit [2:0] f3,
                       input bit [14:0] a, input bit [31:0] wd);
    if (dbg) begin
      bus.d_req_valid = v; bus.d_req_we = we; bus.d_req_funct3 = f3;
      bus.d_req_addr = a;  bus.d_req_wdata = wd;
    end else begin
      bus.c_req_valid = v; bus.c_req_we = we; bus.c_req_funct3 = f3;
      bus.c_req_addr = a;  bus.c_req_wdata = wd;
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.c_req_ready, bus.d_req_ready, bus.c_rsp_valid, bus.d_rsp_valid,
                bus.rsp_err, bus.mem_en, bus.mem_wen})
           | bus.rsp_rdata | bus.mem_wdata | 32'(bus.mem_addr);
  endfunction

  task automatic txn(input bit dbg, input bit we, input bit [2:0] f3, input bit [14:0] a,
                     input bit [31:0] wd, output bit [31:0] got);
    bit err;
    int lat, rsp_at, npulse, nrd, nwr, bad;
    bit [31:0] erd, eww;
    model(we, f3, a, wd, err, lat, erd, eww);
    rsp_at = -1; npulse = 0; nrd = 0; nwr = 0; bad = 0; got = 0;
    @(negedge clk);
    drive(dbg, 1'b1, we, f3, a, wd);
    #1;
    chk("accept", 32'(dbg ? bus.d_req_ready : bus.c_req_ready), 32'd1);
    chk("other_rdy", 32'(dbg ? bus.c_req_ready : bus.d_req_ready), 32'd0);
    @(negedge clk);
    drive(dbg, 1'b0, 1'b0, 3'd0, 15'd0, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.mem_en && bus.mem_wen) begin
        nwr++;
        chk("wdata", bus.mem_wdata, eww);
        chk("waddr", 32'(bus.mem_addr), 32'(a >> 2));
      end else begin
        if (bus.mem_en) nrd++;
        if (bus.mem_wdata != 32'd0) bad++;
      end
      if (dbg ? bus.d_rsp_valid : bus.c_rsp_valid) begin
        npulse++;
        if (rsp_at < 0) rsp_at = k;
        got = bus.rsp_rdata;
        chk("rdata", bus.rsp_rdata, erd);
        chk("err", 32'(bus.rsp_err), 32'(err));
      end else if (bus.rsp_rdata != 32'd0 || bus.rsp_err) bad++;
      if (dbg ? bus.c_rsp_valid : bus.d_rsp_valid) bad++;
    end
    chk("latency", 32'(rsp_at), 32'(lat));
    chk("npulse", 32'(npulse), 32'd1);
    chk("nrd", 32'(nrd), (!err && !(we && f3 == 3'd2)) ? 32'd1 : 32'd0);
    chk("nwr", 32'(nwr), (!err && we) ? 32'd1 : 32'd0);
    chk("quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    bit [31:0] got;
    bit [2:0] lf [5];
    int cnt;
    lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;
    drive(1'b1, 1'b0, 1'b0, 3'd0, 15'd0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 3'd2, 15'd0, 32'd0);

    // Reset: outputs stay 0 even with a valid request pending.
    repeat (3) begin
      @(negedge clk); #1;
      chk("reset_outs", outs(), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 15'd0, 32'd0);
    @(negedge clk);
    chk("post_reset_outs", outs(), 32'd0);

    // Preload 4 regions x 8 words through the DUT.
    for (int r = 0; r < 4; r++)
      for (int w = 0; w < 8; w++)
        txn(1'b0, 1'b1, 3'd2, {2'(r), 8'h00, 3'(w), 2'b00}, $urandom, got);

    txn(1'b0, 1'b1, 3'd2, 15'h0010, 32'h1234_5678, got);
    txn(1'b0, 1'b0, 3'd2, 15'h0010, 32'd0, got);
    chk("lw_const", got, 32'h1234_5678);
    txn(1'b0, 1'b1, 3'd0, 15'h0011, 32'h0000_00AB, got);
    chk("sb_word", tmem[4], 32'h1234_AB78);
    txn(1'b0, 1'b0, 3'd0, 15'h0011, 32'd0, got);
    chk("lb_const", got, 32'hFFFF_FFAB);
    txn(1'b0, 1'b0, 3'd4, 15'h0011, 32'd0, got);
    chk("lbu_const", got, 32'h0000_00AB);
    txn(1'b0, 1'b1, 3'd1, 15'h0012, 32'h0000_8001, got);
    chk("sh_word", tmem[4], 32'h8001_AB78);
    txn(1'b0, 1'b0, 3'd1, 15'h0012, 32'd0, got);
    chk("lh_const", got, 32'hFFFF_8001);
    txn(1'b0, 1'b0, 3'd2, 15'h0013, 32'd0, got);
    txn(1'b0, 1'b1, 3'd3, 15'h0010, 32'hFFFF_FFFF, got);
    chk("err_no_write", tmem[4], 32'h8001_AB78);

    // Reset in the WAIT cycle of an SB: no write, no response.
    txn(1'b0, 1'b1, 3'd2, 15'h0004, 32'h1122_3344, got);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 3'd0, 15'h0005, 32'h0000_005A);
    #1;
    chk("rst_sb_accept", 32'(bus.c_req_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 15'd0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_wait_outs", outs(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_en || bus.c_rsp_valid || bus.d_rsp_valid) cnt++;
    end
    chk("rst_quiet", 32'(cnt), 32'd0);
    chk("rst_mem_kept", tmem[1], 32'h1122_3344);
    txn(1'b0, 1'b0, 3'd2, 15'h0004, 32'd0, got);

`ifdef DMEM_CTRL_DBG_PORT_EN
    begin
      int g[$];
      int last, nrsp, bad, lat;
      bit e;
      bit [31:0] ec, ed, ww;
      model(1'b0, 3'd2, 15'h0000, 32'd0, e, lat, ec, ww);
      model(1'b0, 3'd2, 15'h0004, 32'd0, e, lat, ed, ww);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      last = -1; nrsp = 0; bad = 0;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 3'd2, 15'h0000, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 3'd2, 15'h0004, 32'd0);
      for (int k = 0; k < 24; k++) begin
        #1;
        if (bus.c_req_ready && bus.d_req_ready) bad++;
        if (bus.c_req_ready) begin g.push_back(0); last = 0; end
        if (bus.d_req_ready) begin g.push_back(1); last = 1; end
        if (bus.c_rsp_valid) begin
          nrsp++;
          if (last != 0 || bus.d_rsp_valid) bad++;
          chk("c_rdata", bus.rsp_rdata, ec);
        end
        if (bus.d_rsp_valid) begin
          nrsp++;
          if (last != 1) bad++;
          chk("d_rdata", bus.rsp_rdata, ed);
        end
        if (k == 14) begin
          drive(1'b0, 1'b0, 1'b0, 3'd0, 15'd0, 32'd0);
          drive(1'b1, 1'b0, 1'b0, 3'd0, 15'd0, 32'd0);
        end
        @(negedge clk);
      end
      chk("n_grants", 32'(g.size()), 32'd4);
      for (int i = 0; i < 4 && i < g.size(); i++) chk("grant_order", 32'(g[i]), 32'(i % 2));
      chk("n_rsp", 32'(nrsp), 32'd4);
      chk("rsp_owner", 32'(bad), 32'd0);
    end
`else
    cnt = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 3'd2, 15'h0008, 32'hDEAD_BEEF);
    repeat (8) begin
      #1;
      if (bus.d_req_ready || bus.mem_en || bus.d_rsp_valid || bus.c_rsp_valid) cnt++;
      @(negedge clk);
    end
    drive(1'b1, 1'b0, 1'b0, 3'd0, 15'd0, 32'd0);
    chk("dbg_ignored", 32'(cnt), 32'd0);
    txn(1'b0, 1'b0, 3'd2, 15'h0008, 32'd0, got);
`endif

    for (int n = 0; n < 300; n++) begin
      bit dbg, we;
      bit [2:0] f3;
`ifdef DMEM_CTRL_DBG_PORT_EN
      dbg = 1'($urandom);
`else
      dbg = 1'b0;
`endif
      we = 1'($urandom);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else f3 = we ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      txn(dbg, we, f3, {2'($urandom), 8'h00, 5'($urandom)}, $urandom, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
